// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the data RAM port arbiter.
// Holds the owner state encoding and master id constants.
package dram_arb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic M_CORE = 1'b0;
    localparam logic M_DBG  = 1'b1;

endpackage

// File: rtl/dram_arb_rsel.sv
// Two-way one-hot payload select for the RAM request side.
// Output is all zeros when neither input is selected.
module dram_arb_rsel #(
    parameter int W = 8
) (
    input  logic         sel0,
    input  logic         sel1,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] q
);

    // Select the granted payload, zero when idle
    always_comb begin
        q = '0;
        if (sel0) begin
            q = d0;
        end else if (sel1) begin
            q = d1;
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the single-port data RAM between core LSU and debug port.
// Define DRAM_ARB_RR_EN for round-robin arbitration when idle.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_lock,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_lock,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            ram_ce,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    output logic [DW/8-1:0] ram_wstrb,
    input  logic [DW-1:0]   ram_rdata
);

    localparam int PW = 1 + AW + DW + DW / 8;
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    arb_state_e state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       rd_vld_q, rd_vld_d;
    logic       rd_id_q, rd_id_d;
    logic       g0, g1;
    logic [PW-1:0] sel_q;

`ifdef DRAM_ARB_RR_EN
    logic last_q, last_d;
`endif

    assign m0_gnt = g0 & ~rst;
    assign m1_gnt = g1 & ~rst;
    assign ram_ce = m0_gnt | m1_gnt;

    dram_arb_rsel #(.W(PW)) u_rsel (
        .sel0 (m0_gnt),
        .sel1 (m1_gnt),
        .d0   ({m0_we, m0_addr, m0_wdata, m0_wstrb}),
        .d1   ({m1_we, m1_addr, m1_wdata, m1_wstrb}),
        .q    (sel_q)
    );

    assign {ram_we, ram_addr, ram_wdata, ram_wstrb} = sel_q;

    assign m0_rvalid = rd_vld_q & (rd_id_q == M_CORE);
    assign m1_rvalid = rd_vld_q & (rd_id_q == M_DBG);
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

    // Grant selection, ownership/hold tracking and read tag capture
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        rd_vld_d = 1'b0;
        rd_id_d  = rd_id_q;
        g0       = 1'b0;
        g1       = 1'b0;
`ifdef DRAM_ARB_RR_EN
        last_d   = last_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef DRAM_ARB_RR_EN
                if (m0_req && m1_req) begin
                    g0 = (last_q == M_DBG);
                    g1 = (last_q == M_CORE);
                end else begin
                    g0 = m0_req;
                    g1 = m1_req;
                end
`else
                g0 = m0_req;
                g1 = m1_req & ~m0_req;
`endif
            end
            OWN0: g0 = m0_req;
            OWN1: g1 = m1_req;
            default: ;
        endcase

        if (g0) begin
            if (m0_lock && hold_q < HOLD_LIM) begin
                state_d = OWN0;
                hold_d  = hold_q + 8'd1;
            end else begin
                state_d = IDLE;
                hold_d  = '0;
            end
        end else if (g1) begin
            if (m1_lock && hold_q < HOLD_LIM) begin
                state_d = OWN1;
                hold_d  = hold_q + 8'd1;
            end else begin
                state_d = IDLE;
                hold_d  = '0;
            end
        end else if (state_q != IDLE) begin
            state_d = IDLE;
            hold_d  = '0;
        end

        if (g0 || g1) begin
            rd_vld_d = ~ram_we;
            rd_id_d  = g1 ? M_DBG : M_CORE;
`ifdef DRAM_ARB_RR_EN
            last_d   = g1 ? M_DBG : M_CORE;
`endif
        end
    end

    // Owner state, hold counter and outstanding read tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            rd_vld_q <= 1'b0;
            rd_id_q  <= M_CORE;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rd_vld_q <= rd_vld_d;
            rd_id_q  <= rd_id_d;
        end
    end

`ifdef DRAM_ARB_RR_EN
    // Most recently granted master for round-robin fairness
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= M_DBG;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter with MAX_HOLD=4.
// Directed vectors push expected grant/rvalid events per cycle.
module tb_dram_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

`ifdef DRAM_ARB_RR_EN
    localparam int C2 = 2;
`else
    localparam int C2 = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          m0_req, m0_lock, m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [3:0]    m0_wstrb;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_lock, m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [3:0]    m1_wstrb;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [3:0]    ram_wstrb;
    logic [DW-1:0] ram_rdata;

    dram_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_HOLD(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock),
        .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock),
        .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata)
    );

    logic [31:0] mem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        ram_rdata = '0;
    end

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wstrb[b])
                        mem[ram_addr[13:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[13:2]];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          rv;
        bit          id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ev_t;

    ev_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check_ev(input bit rv, input bit id,
                            input logic we,
                            input logic [31:0] addr,
                            input logic [31:0] data,
                            input logic [3:0] strb);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s m%0d cyc %0d: got data=%h, required none",
                     rv ? "rvalid" : "gnt", id, cyc, data);
            return;
        end
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.rv != rv || e.id != id ||
            e.we !== we || e.addr !== addr ||
            e.data !== data || e.strb !== strb) begin
            errors++;
            $display("FAIL %s_m%0d: got cyc=%0d rv=%0d we=%b addr=%h data=%h strb=%h required cyc=%0d rv=%0d id=%0d we=%b addr=%h data=%h strb=%h",
                     rv ? "rvalid" : "gnt", id, cyc, rv, we, addr, data, strb,
                     e.cyc, e.rv, e.id, e.we, e.addr, e.data, e.strb);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if ({m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
                 ram_ce, ram_we, ram_addr, ram_wdata, ram_wstrb} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: got gnt=%b%b rv=%b%b ce=%b, required all 0",
                         cyc, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ce);
            end
        end else begin
            if (m0_rvalid) check_ev(1'b1, 1'b0, 1'b0, '0, m0_rdata, '0);
            if (m1_rvalid) check_ev(1'b1, 1'b1, 1'b0, '0, m1_rdata, '0);
            if (m0_gnt) check_ev(1'b0, 1'b0, ram_we, ram_addr, ram_wdata, ram_wstrb);
            if (m1_gnt) check_ev(1'b0, 1'b1, ram_we, ram_addr, ram_wdata, ram_wstrb);
            checks++;
            if ((!m0_rvalid && m0_rdata !== '0) ||
                (!m1_rvalid && m1_rdata !== '0) ||
                (ram_ce !== (m0_gnt | m1_gnt)) ||
                (!ram_ce && {ram_we, ram_addr, ram_wdata, ram_wstrb} !== '0)) begin
                errors++;
                $display("FAIL quiet_outputs cyc %0d: got ce=%b we=%b addr=%h r0=%h r1=%h, required idle zeros",
                         cyc, ram_ce, ram_we, ram_addr, m0_rdata, m1_rdata);
            end
        end
    end

    task automatic step(input logic r,
                        input logic r0, input logic l0, input logic w0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic [3:0] s0,
                        input logic r1, input logic l1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input logic [3:0] s1,
                        input int eg, input int erv,
                        input logic [31:0] erd);
        ev_t e;
        @(posedge clk);
        #1;
        rst = r;
        m0_req = r0; m0_lock = l0; m0_we = w0;
        m0_addr = a0; m0_wdata = d0; m0_wstrb = s0;
        m1_req = r1; m1_lock = l1; m1_we = w1;
        m1_addr = a1; m1_wdata = d1; m1_wstrb = s1;
        if (erv != 0) begin
            e.cyc = cyc; e.rv = 1'b1; e.id = (erv == 2);
            e.we = 1'b0; e.addr = '0; e.data = erd; e.strb = '0;
            exp_q.push_back(e);
        end
        if (eg != 0) begin
            e.cyc = cyc; e.rv = 1'b0; e.id = (eg == 2);
            e.we = (eg == 2) ? w1 : w0;
            e.addr = (eg == 2) ? a1 : a0;
            e.data = (eg == 2) ? d1 : d0;
            e.strb = (eg == 2) ? s1 : s0;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input logic r, input int erv,
                        input logic [31:0] erd);
        step(r, 0, 0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0, 0, erv, erd);
    endtask

    initial begin
        m0_req = 1; m0_lock = 0; m0_we = 1;
        m0_addr = 32'h10; m0_wdata = 32'hA5; m0_wstrb = 4'hF;
        m1_req = 1; m1_lock = 0; m1_we = 0;
        m1_addr = 32'h20; m1_wdata = 32'h5A; m1_wstrb = 4'hF;
        repeat (2) @(posedge clk);
        idle(0, 0, 0);

        // contention, no lock
        step(0, 1, 0, 1, 32'h2000, 32'h1111_1111, 4'hF,
                1, 0, 1, 32'h3000, 32'h2222_2222, 4'hF, 1, 0, 0);
        step(0, 1, 0, 1, 32'h2000, 32'h1111_1111, 4'hF,
                1, 0, 1, 32'h3000, 32'h2222_2222, 4'hF, C2, 0, 0);
        step(0, 1, 0, 1, 32'h2000, 32'h1111_1111, 4'hF,
                1, 0, 1, 32'h3000, 32'h2222_2222, 4'hF, 1, 0, 0);
        step(0, 0, 0, 0, '0, '0, '0,
                1, 0, 1, 32'h3000, 32'h2222_2222, 4'hF, 2, 0, 0);
        idle(0, 0, 0);

        // read data routing
        step(0, 0, 0, 0, '0, '0, '0,
                1, 0, 1, 32'h1000, 32'h0FF0_00FF, 4'hF, 2, 0, 0);
        step(0, 1, 0, 0, 32'h1000, '0, '0,
                0, 0, 0, '0, '0, '0, 1, 0, 0);
        idle(0, 1, 32'h0FF0_00FF);

        // byte write then readback
        step(0, 1, 0, 1, 32'h1004, 32'h0000_AB00, 4'b0010,
                0, 0, 0, '0, '0, '0, 1, 0, 0);
        step(0, 1, 0, 0, 32'h1004, '0, '0,
                0, 0, 0, '0, '0, '0, 1, 0, 0);
        idle(0, 1, 32'h0000_AB00);

        // back-to-back reads, grant and rvalid of different masters
        step(0, 0, 0, 0, '0, '0, '0,
                1, 0, 0, 32'h1000, '0, '0, 2, 0, 0);
        step(0, 1, 0, 0, 32'h1004, '0, '0,
                0, 0, 0, '0, '0, '0, 1, 2, 32'h0FF0_00FF);
        idle(0, 1, 32'h0000_AB00);

        // lock bound with MAX_HOLD=4
        step(0, 0, 0, 0, '0, '0, '0,
                1, 1, 1, 32'h3004, 32'h33, 4'hF, 2, 0, 0);
        for (int k = 0; k < 3; k++)
            step(0, 1, 0, 1, 32'h2004, 32'h44, 4'hF,
                    1, 1, 1, 32'h3004, 32'h33, 4'hF, 2, 0, 0);
        step(0, 1, 0, 1, 32'h2004, 32'h44, 4'hF,
                1, 1, 1, 32'h3004, 32'h33, 4'hF, 1, 0, 0);
        step(0, 0, 0, 0, '0, '0, '0,
                1, 1, 1, 32'h3004, 32'h33, 4'hF, 2, 0, 0);
        idle(0, 0, 0);

        // owner drop
        step(0, 1, 1, 1, 32'h2008, 32'h55, 4'hF,
                0, 0, 0, '0, '0, '0, 1, 0, 0);
        step(0, 1, 1, 1, 32'h2008, 32'h55, 4'hF,
                1, 0, 1, 32'h3008, 32'h66, 4'hF, 1, 0, 0);
        step(0, 0, 0, 0, '0, '0, '0,
                1, 0, 1, 32'h3008, 32'h66, 4'hF, 0, 0, 0);
        step(0, 0, 0, 0, '0, '0, '0,
                1, 0, 1, 32'h3008, 32'h66, 4'hF, 2, 0, 0);
        idle(0, 0, 0);

        // reset while a locked read is in flight
        step(0, 1, 1, 0, 32'h1000, '0, '0,
                0, 0, 0, '0, '0, '0, 1, 0, 0);
        idle(1, 0, 0);
        idle(1, 0, 0);
        idle(0, 0, 0);
        step(0, 0, 0, 0, '0, '0, '0,
                1, 0, 1, 32'h300C, 32'h77, 4'hF, 2, 0, 0);
        idle(0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending, required 0",
                     exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters.
  - Master 0: core load/store unit.
  - Master 1: debug/loader port, which preloads signature data and inspects results.
- Sits between the core/debug logic and the data RAM inside the SoC top.
- Each cycle it grants at most one master, muxes that master onto the RAM port, and routes read data back one cycle later.
- Supports locked multi-beat ownership, bounded by a hold counter.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
MAX_HOLD, 8, maximum consecutive granted cycles for a locked owner before forced release; legal range 1..255

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
m0_req  in  1  master 0 access request
m0_lock  in  1  master 0 requests to keep ownership after the current beat
m0_we  in  1  master 0 write enable
m0_addr  in  AW  master 0 byte address
m0_wdata  in  DW  master 0 write data
m0_wstrb  in  DW/8  master 0 byte strobes
m0_gnt  out  1  master 0 beat accepted this cycle
m0_rvalid  out  1  master 0 read data valid
m0_rdata  out  DW  master 0 read data
m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_gnt, m1_rvalid, m1_rdata  same directions, widths and meanings, for master 1
ram_ce  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM byte address
ram_wdata  out  DW  RAM write data
ram_wstrb  out  DW/8  RAM byte strobes
ram_rdata  in  DW  RAM read data, valid one cycle after ram_ce with ram_we=0

Behaviour:
- State machine, state register encodes owner: IDLE, OWN0, OWN1.
- Arbitration:
  - IDLE: if m0_req, grant m0; else if m1_req, grant m1 (fixed priority m0).
  - OWNx: grant only mx while mx_req=1; the other master waits.
- Grant timing:
  - mx_gnt is combinational from state and req.
  - The granted beat drives ram_* combinationally the same cycle: ram_ce=1, with we/addr/wdata/wstrb taken from the winner.
  - When no master is granted: ram_ce=0, ram_we=0, all other ram_* outputs 0.
- Transitions at a granted beat of mx:
  - mx_lock=1 and hold_cnt<MAX_HOLD-1 -> OWNx, hold_cnt+1.
  - Otherwise -> IDLE, hold_cnt=0.
- Owner drop: OWNx with mx_req=0 -> IDLE next cycle, no grant this cycle, hold_cnt=0.
- Forced release: on reaching MAX_HOLD the state returns to IDLE even if lock=1.
  - If both masters request in the next IDLE cycle, the priority rule applies again.
  - MAX_HOLD=1 disables locking.
- hold_cnt: 8 bits; saturation is not reachable given the legal parameter range.
- Read return:
  - Registered rd_tag (valid + owner id) is captured on a granted read.
  - The next cycle asserts mx_rvalid=1 for that owner, with mx_rdata = ram_rdata.
  - Non-owner rdata = 0.
  - Writes produce no rvalid.
  - Back-to-back reads give one rvalid per cycle.
- Simultaneous events:
  - A grant and an rvalid for a different master may occur in the same cycle; rvalid follows rd_tag, never the current grant.
- Reset, asynchronous:
  - State -> IDLE; hold_cnt=0; rd_tag valid=0; last_gnt=1.
  - All outputs 0: gnt, rvalid, rdata, ram_*.
  - A read in flight at reset is dropped; no rvalid is issued after reset deasserts.
- Requests are level-sensitive. A master holds req and its payload stable until it sees gnt; the arbiter does not latch ungranted requests.

Optional Feature:
- Macro: DRAM_ARB_RR_EN.
- Defined:
  - IDLE arbitration is round-robin.
  - A 1-bit last_gnt register, updated on every grant, gives priority to the master not granted most recently; reset value 1, so m0 wins first.
- Undefined:
  - Fixed priority m0 over m1.
  - last_gnt is not implemented.

Decomposition:
- Shared package dram_arb_pkg:
  - State enum: IDLE=2'd0, OWN0=2'd1, OWN1=2'd2.
  - Master id constants M_CORE=1'b0, M_DBG=1'b1.
  - Default AW/DW localparams.
- One natural sub-module, dram_arb_rsel: the 2-way payload mux with zero default, instantiated for the RAM-side request mux.

Test Plan:
- Reset mid-read:
  - m0 read at addr 0x1000 granted, rst pulsed in the following cycle.
  - Required: m0_rvalid stays 0, all outputs 0 during reset, state IDLE after.
- Contention:
  - m0_req=m1_req=1 in the same cycle, no lock.
  - Required, fixed priority: m0 granted in both cycles 1 and 2 while it keeps requesting; m1 granted once m0_req drops.
  - Required, with DRAM_ARB_RR_EN: alternating m0, m1, m0.
- Read data routing:
  - m1 writes 0x0FF000FF with wstrb=4'hF to 0x1000, then m0 reads 0x1000.
  - Required: m0_rvalid=1 one cycle after m0_gnt, m0_rdata=0x0FF000FF, m1_rvalid=0.
- Lock bound, MAX_HOLD=4:
  - m1 holds lock=1 and req=1 while m0 requests continuously.
  - Required: m1 granted exactly 4 consecutive cycles, then m0 granted in the next IDLE arbitration cycle.
- Byte write:
  - m0 writes wstrb=4'b0010, wdata=0x0000AB00 to 0x1004.
  - Required: ram_ce=1, ram_we=1, ram_wstrb=4'b0010, ram_addr=0x1004 in the grant cycle; no rvalid.
- Owner drop:
  - m0 is locked owner and deasserts req.
  - Required: no grant that cycle, IDLE next cycle, m1 granted in the next arbitration cycle.
